// File: rtl/btn_event_pkg.sv
// Shared types and helpers for the push-button event front-end.
package btn_event_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HELD     = 2'd1,
    ST_LONGHELD = 2'd2
  } chan_state_e;

  localparam logic EVT_SHORT = 1'b0;
  localparam logic EVT_LONG  = 1'b1;

  // Event id width; a single button still gets a 1-bit id.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_chan.sv
// One button channel: synchroniser, debounce filter and SHORT/LONG press classifier.
module btn_chan
  import btn_event_pkg::*;
#(
  parameter int DB_CYCLES   = 1000,
  parameter int LONG_CYCLES = 50000,
  parameter int CNT_W       = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic level,
  output logic evt_raise,
  output logic evt_is_long
);

  logic             sync1_r;
  logic             sync2_r;
  logic [CNT_W-1:0] db_cnt_r;
  logic [CNT_W-1:0] db_cnt_nxt_s;
  logic             level_r;
  logic             level_nxt_s;
  logic [CNT_W-1:0] hold_cnt_r;
  chan_state_e      state_r;
  logic             raise_r;
  logic             long_r;

  // Debounce next-state: count consecutive disagreeing cycles, toggle on the last one.
  always_comb begin
    level_nxt_s  = level_r;
    db_cnt_nxt_s = '0;
    if ((~sync2_r) != level_r) begin
      if (db_cnt_r == CNT_W'(DB_CYCLES - 1)) begin
        level_nxt_s  = ~level_r;
        db_cnt_nxt_s = '0;
      end else begin
        db_cnt_nxt_s = db_cnt_r + CNT_W'(1);
      end
    end else begin
      db_cnt_nxt_s = '0;
    end
  end

  // Synchroniser (idles at released) and debounced level register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r  <= 1'b1;
      sync2_r  <= 1'b1;
      db_cnt_r <= '0;
      level_r  <= 1'b0;
    end else begin
      sync1_r  <= btn_n;
      sync2_r  <= sync1_r;
      db_cnt_r <= db_cnt_nxt_s;
      level_r  <= level_nxt_s;
    end
  end

  // Press classifier; reacts to the debounced level on the edge it changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      hold_cnt_r <= '0;
      raise_r    <= 1'b0;
      long_r     <= EVT_SHORT;
    end else begin
      raise_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (level_nxt_s) begin
            state_r    <= ST_HELD;
            hold_cnt_r <= '0;
          end
        end
        ST_HELD: begin
          if (!level_nxt_s) begin
            raise_r <= 1'b1;
            long_r  <= EVT_SHORT;
            state_r <= ST_IDLE;
          end else if (hold_cnt_r == CNT_W'(LONG_CYCLES - 1)) begin
            raise_r <= 1'b1;
            long_r  <= EVT_LONG;
            state_r <= ST_LONGHELD;
          end else begin
            hold_cnt_r <= hold_cnt_r + CNT_W'(1);
          end
        end
        ST_LONGHELD: begin
          if (!level_nxt_s) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign level       = level_r;
  assign evt_raise   = raise_r;
  assign evt_is_long = long_r;

endmodule

// File: rtl/btn_event_ctrl.sv
// Push-button front-end: per-button channels, one pending slot each, and a
// round-robin arbiter feeding a single registered valid/ready event stream.
module btn_event_ctrl
  import btn_event_pkg::*;
#(
  parameter int  N_BTN       = 4,
  parameter int  DB_CYCLES   = 1000,
  parameter int  LONG_CYCLES = 50000,
  parameter int  CNT_W       = 16,
  localparam int ID_W        = id_width(N_BTN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_n,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [ID_W-1:0]  evt_id,
  output logic             evt_long,
  output logic             evt_ovf,
  output logic [N_BTN-1:0] btn_level
);

  logic [N_BTN-1:0] raise_s;
  logic [N_BTN-1:0] is_long_s;
  logic [N_BTN-1:0] pend_r;
  logic [N_BTN-1:0] pend_long_r;
  logic [N_BTN-1:0] drain_s;
  logic [N_BTN-1:0] drop_s;
  logic [ID_W-1:0]  rr_ptr_r;
  logic [ID_W-1:0]  sel_s;
  logic             sel_long_s;
  logic             found_s;
  logic             load_s;
  int               dist_s;
  int               best_s;

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    btn_chan #(
      .DB_CYCLES  (DB_CYCLES),
      .LONG_CYCLES(LONG_CYCLES),
      .CNT_W      (CNT_W)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_n      (btn_n[g]),
      .level      (btn_level[g]),
      .evt_raise  (raise_s[g]),
      .evt_is_long(is_long_s[g])
    );
  end

  assign load_s = !evt_valid || evt_ready;

  // Round-robin pick: the set slot closest above the pointer, wrapping.
  always_comb begin
    found_s    = 1'b0;
    sel_s      = '0;
    sel_long_s = 1'b0;
    best_s     = N_BTN;
    dist_s     = 0;
    for (int i = 0; i < N_BTN; i++) begin
      if (i >= int'(rr_ptr_r)) begin
        dist_s = i - int'(rr_ptr_r);
      end else begin
        dist_s = i + N_BTN - int'(rr_ptr_r);
      end
      if (pend_r[i] && (dist_s < best_s)) begin
        best_s     = dist_s;
        found_s    = 1'b1;
        sel_s      = ID_W'(i);
        sel_long_s = pend_long_r[i];
      end
    end
  end

  // A new event collides only with a slot that is full and not leaving this cycle.
  always_comb begin
    drain_s = '0;
    drop_s  = '0;
    for (int i = 0; i < N_BTN; i++) begin
      drain_s[i] = load_s && found_s && (sel_s == ID_W'(i));
      drop_s[i]  = raise_s[i] && pend_r[i] && !drain_s[i];
    end
  end

  // Pending slots and overflow pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r      <= '0;
      pend_long_r <= '0;
      evt_ovf     <= 1'b0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (raise_s[i]) begin
          if (!drop_s[i]) begin
            pend_r[i]      <= 1'b1;
            pend_long_r[i] <= is_long_s[i];
          end
        end else if (drain_s[i]) begin
          pend_r[i] <= 1'b0;
        end
      end
      evt_ovf <= |drop_s;
    end
  end

  // Output stage; id/long only change on a load so they hold under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_id    <= '0;
      evt_long  <= 1'b0;
      rr_ptr_r  <= '0;
    end else if (load_s) begin
      if (found_s) begin
        evt_valid <= 1'b1;
        evt_id    <= sel_s;
        evt_long  <= sel_long_s;
        rr_ptr_r  <= (sel_s == ID_W'(N_BTN - 1)) ? '0 : sel_s + ID_W'(1);
      end else begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule
